// File: rtl/decapsulation_pkg.sv
// decapsulation_pkg: shared states, error codes, framing and CRC-32 constants
package decapsulation_pkg;
    typedef enum logic [3:0] {IDLE, PRE, DST, SRC, LEN, PAY, PAD, FCS, WAIT} state_t;
    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_LEN = 3'd1;
    localparam logic [2:0] ERR_ADDR = 3'd2;
    localparam logic [2:0] ERR_TRUNC = 3'd3;
    localparam logic [2:0] ERR_CRC = 3'd4;
    localparam logic [2:0] ERR_OVF = 3'd5;
    localparam logic [7:0] PREAMBLE = 8'h55;
    localparam logic [7:0] SFD = 8'hD5;
    localparam logic [15:0] MIN_PAYLOAD = 16'd46;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction
    localparam logic [31:0] CRC_POLY_REF = reflect32(CRC_POLY);
endpackage

// File: rtl/decapsulation_if.sv
// decapsulation_if: receive byte stream in, payload writes and frame status out
interface decapsulation_if;
    logic rx_dv;
    logic [7:0] rx_data;
    logic buf_full;
    logic wr_en;
    logic [7:0] wr_data;
    logic frame_ok;
    logic frame_err;
    logic [2:0] err_code;
    logic [47:0] src_mac;
    logic [15:0] len_out;
    modport master (
        output rx_dv, rx_data, buf_full,
        input wr_en, wr_data, frame_ok, frame_err, err_code, src_mac, len_out
    );
    modport slave (
        input rx_dv, rx_data, buf_full,
        output wr_en, wr_data, frame_ok, frame_err, err_code, src_mac, len_out
    );
endinterface

// File: rtl/crc32_comb.sv
// crc32_comb: one-byte update of a reflected CRC-32 register
module crc32_comb
    import decapsulation_pkg::*;
(
    input logic [31:0] crc_in,
    input logic [7:0] data,
    output logic [31:0] crc_out
);
    always_comb begin
        crc_out = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) crc_out = crc_out[0] ? (crc_out >> 1) ^ CRC_POLY_REF : crc_out >> 1;
    end
endmodule

// File: rtl/decapsulation.sv
// decapsulation: Ethernet frame parser writing payload bytes and flagging good/bad frames
module decapsulation
    import decapsulation_pkg::*;
#(
    parameter logic [47:0] MY_MAC = 48'h023528fbdd66,
    parameter logic [15:0] MAX_LEN = 16'd1500
) (
    input logic eth_tx_clk,
    input logic rst,
    decapsulation_if.slave bus
);
    state_t state, state_n;
    logic [15:0] cnt, len_r, pad_n, len_full;
    logic [47:0] dst_sh, src_sh, dst_full;
    logic [31:0] crc, crc_nx;
    logic crc_en, wr_n, ok_n, err_n;
    logic [2:0] code_n;
    assign dst_full = {dst_sh[39:0], bus.rx_data};
    assign len_full = {len_r[7:0], bus.rx_data};
    assign pad_n = (len_r < MIN_PAYLOAD) ? MIN_PAYLOAD - len_r : '0;
    // FCS bytes also run through the CRC so a good frame lands on the fixed residue
    assign crc_en = bus.rx_dv && (state inside {DST, SRC, LEN, PAY, PAD, FCS});
    crc32_comb u_crc (.crc_in(crc), .data(bus.rx_data), .crc_out(crc_nx));
    always_comb begin
        state_n = state;
        wr_n = 1'b0;
        ok_n = 1'b0;
        err_n = 1'b0;
        code_n = ERR_NONE;
        if (state inside {DST, SRC, LEN, PAY, PAD, FCS} && !bus.rx_dv) begin
            state_n = IDLE;
            err_n = 1'b1;
            code_n = ERR_TRUNC;
        end else begin
            case (state)
                IDLE: if (bus.rx_dv) state_n = (bus.rx_data == PREAMBLE) ? PRE : WAIT;
                PRE: begin
                    if (!bus.rx_dv) state_n = IDLE;
                    else if (bus.rx_data == SFD) state_n = DST;
                    else if (bus.rx_data != PREAMBLE || cnt >= 16'd6) state_n = WAIT;
                end
                DST: if (cnt == 16'd5) begin
                    err_n = dst_full != MY_MAC && dst_full != BCAST;
                    code_n = err_n ? ERR_ADDR : ERR_NONE;
                    state_n = err_n ? WAIT : SRC;
                end
                SRC: if (cnt == 16'd5) state_n = LEN;
                LEN: if (cnt == 16'd1) begin
                    err_n = len_full > MAX_LEN;
                    code_n = err_n ? ERR_LEN : ERR_NONE;
                    state_n = err_n ? WAIT : (len_full == 16'd0) ? PAD : PAY;
                end
                PAY: begin
                    if (bus.buf_full) begin
                        state_n = WAIT;
                        err_n = 1'b1;
                        code_n = ERR_OVF;
                    end else begin
                        wr_n = 1'b1;
                        if (cnt == len_r - 16'd1) state_n = (len_r < MIN_PAYLOAD) ? PAD : FCS;
                    end
                end
                PAD: if (cnt == pad_n - 16'd1) state_n = FCS;
                FCS: if (cnt == 16'd3) begin
                    state_n = WAIT;
                    ok_n = crc_nx == CRC_RESIDUE;
                    err_n = !ok_n;
                    code_n = ok_n ? ERR_NONE : ERR_CRC;
                end
                WAIT: if (!bus.rx_dv) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge eth_tx_clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            len_r <= '0;
            dst_sh <= '0;
            src_sh <= '0;
            crc <= CRC_INIT;
            bus.wr_en <= 1'b0;
            bus.wr_data <= '0;
            bus.frame_ok <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.err_code <= '0;
            bus.src_mac <= '0;
            bus.len_out <= '0;
        end else begin
            state <= state_n;
            cnt <= (state_n != state) ? '0 : cnt + {15'd0, bus.rx_dv};
            crc <= (state == IDLE) ? CRC_INIT : crc_en ? crc_nx : crc;
            bus.wr_en <= wr_n;
            bus.wr_data <= wr_n ? bus.rx_data : bus.wr_data;
            bus.frame_ok <= ok_n;
            bus.frame_err <= err_n;
            bus.err_code <= code_n;
            if (ok_n) bus.src_mac <= src_sh;
            if (ok_n) bus.len_out <= len_r;
            if (bus.rx_dv && state == DST) dst_sh <= dst_full;
            if (bus.rx_dv && state == SRC) src_sh <= {src_sh[39:0], bus.rx_data};
            if (bus.rx_dv && state == LEN) len_r <= len_full;
        end
    end
endmodule
